// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, widths and round-robin search helper for the UART TX arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, START, SHIFT} arb_state_t;

    localparam int UART_DATA_W = 8;
    localparam int MAX_REQ     = 8;

    // First set bit of mask at or after ptr, wrapping; bits at or above the
    // real requester count are zero, so wrapping at MAX_REQ is equivalent.
    function automatic int rr_next(input int ptr, input logic [MAX_REQ-1:0] mask);
        int idx;
        logic found;
        rr_next = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (ptr + i) % MAX_REQ;
            if (mask[idx] && !found) begin
                rr_next = idx;
                found = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin pick of the first valid requester at or after rr_ptr
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      index,
    output logic               any
);

    assign any   = |mask;
    assign index = IW'(rr_next(int'(rr_ptr), MAX_REQ'(mask)));
    assign grant = any ? (NUM_REQ'(1) << index) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ valid/ready byte sources (optional UART_ARB_LOCK_EN adds req_last packet locking)
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                      txclk,
    input  logic                      reset_n,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_last,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      ld_tx_data,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_enable,
    input  logic                      tx_empty,
    output logic                      busy,
    output logic [IW-1:0]             grant_id
);

    arb_state_t         state, state_nx;
    logic [IW-1:0]      grant, rr_ptr, pick_idx;
    logic [NUM_REQ-1:0] grant_oh, pick_oh;
    logic               pick_any, locked, go;

    uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .mask   (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_oh),
        .index  (pick_idx),
        .any    (pick_any)
    );

    // Next state: grant only when enabled and the UART is free; a locked source must itself be valid
    always_comb begin
        go       = arb_en & tx_empty & (locked ? req_valid[grant] : pick_any);
        state_nx = state == IDLE  ? (go ? LOAD : IDLE) :
                   state == LOAD  ? START :
                   state == START ? (tx_empty ? START : SHIFT) :
                                    (tx_empty ? IDLE : SHIFT);
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_oh <= '0;
            rr_ptr   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && go && !locked) begin
                grant    <= pick_idx;
                grant_oh <= pick_oh;
            end
            if (state == SHIFT && tx_empty && !locked)
                rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

`ifdef UART_ARB_LOCK_EN
    // Lock onto the granted source until it hands over a byte marked last
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n)
            locked <= 1'b0;
        else if (state == LOAD)
            locked <= ~req_last[grant];
    end
`else
    assign locked = 1'b0;
`endif

    assign ld_tx_data = state == LOAD;
    assign tx_enable  = state != IDLE;
    assign busy       = state != IDLE;
    assign grant_id   = grant;
    assign tx_data    = ld_tx_data ? req_data[grant*DATA_W +: DATA_W] : '0;
    assign req_ready  = ld_tx_data ? (grant_oh & req_valid) : '0;

endmodule
